// File: rtl/multiply_add_unit_if.sv
// multiply_add_unit_if: operand/result bundle for the butterfly datapath.
// Master drives A, B, w and observes Y, Z; the datapath is the slave.
interface multiply_add_unit_if;
    logic [31:0] A, B, w, Y, Z;
    modport master (output A, B, w, input Y, Z);
    modport slave (input A, B, w, output Y, Z);
endinterface

// File: rtl/multiply_add_unit.sv
// multiply_add_unit: 3-stage radix-2 butterfly, Y = A + w*B, Z = A - w*B, Q6.10 complex.
// Define SATURATE_EN to clamp the output sums to 16 bits instead of wrapping.
module multiply_add_unit (
    input logic Clk,
    input logic Rst_n,
    multiply_add_unit_if.slave bus
);
    logic [31:0] a1_q, b1_q, w1_q, a2_q, y_q, z_q, y_d, z_d;
    logic signed [31:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [15:0] br, bi, wr, wi;
    logic signed [22:0] prs, pis;
    logic signed [23:0] ar, ai;

    function automatic logic [15:0] narrow(input logic signed [23:0] s);
`ifdef SATURATE_EN
        return (s > 24'sd32767) ? 16'h7fff : (s < -24'sd32768) ? 16'h8000 : 16'(s);
`else
        return 16'(s);
`endif
    endfunction

    assign br = b1_q[31:16];
    assign bi = b1_q[15:0];
    assign wr = w1_q[31:16];
    assign wi = w1_q[15:0];

    // Full 33-bit precision before the floor shift back to Q6.10
    assign prs = 23'((33'(rr_q) - 33'(ii_q)) >>> 10);
    assign pis = 23'((33'(ri_q) + 33'(ir_q)) >>> 10);
    assign ar = 24'($signed(a2_q[31:16]));
    assign ai = 24'($signed(a2_q[15:0]));

    always_comb begin
        y_d = {narrow(ar + 24'(prs)), narrow(ai + 24'(pis))};
        z_d = {narrow(ar - 24'(prs)), narrow(ai - 24'(pis))};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a1_q <= '0;
            b1_q <= '0;
            w1_q <= '0;
            a2_q <= '0;
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
            y_q  <= '0;
            z_q  <= '0;
        end else begin
            a1_q <= bus.A;
            b1_q <= bus.B;
            w1_q <= bus.w;
            a2_q <= a1_q;
            rr_q <= 32'(wr) * 32'(br);
            ii_q <= 32'(wi) * 32'(bi);
            ri_q <= 32'(wr) * 32'(bi);
            ir_q <= 32'(wi) * 32'(br);
            y_q  <= y_d;
            z_q  <= z_d;
        end
    end

    assign bus.Y = y_q;
    assign bus.Z = z_q;
endmodule

// File: tb/tb_multiply_add_unit.sv
// tb_multiply_add_unit: randomized butterfly stimulus checked against an arithmetic model,
// plus literal vectors pinning the model and the pipeline/reset behaviour.
module tb_multiply_add_unit;
    logic Clk = 0;
    logic Rst_n = 1;
    multiply_add_unit_if bif();
    multiply_add_unit dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bif));

    always #5 Clk = ~Clk;

    int errors = 0, checks = 0, n = 0, valid_from = 1;
    logic [63:0] hist [0:4095];

    function automatic logic [15:0] nar(longint s);
`ifdef SATURATE_EN
        if (s > 32767) return 16'h7fff;
        if (s < -32768) return 16'h8000;
`endif
        return 16'(s);
    endfunction

    // Butterfly in plain integer arithmetic; returns {Y, Z}
    function automatic logic [63:0] bfly(logic [31:0] a, logic [31:0] b, logic [31:0] w);
        longint ar, ai, br, bi, wr, wi, pr, pi;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        wr = longint'($signed(w[31:16]));
        wi = longint'($signed(w[15:0]));
        pr = (wr * br - wi * bi) >>> 10;
        pi = (wr * bi + wi * br) >>> 10;
        return {nar(ar + pr), nar(ai + pi), nar(ar - pr), nar(ai - pi)};
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got Y/Z=%h expected Y/Z=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rc();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return 16'h7fff;
            1: return 16'h8000;
            2: return 16'h0400;
            default: return r[15:0];
        endcase
    endfunction

    task automatic drive_rand();
        bif.A = {rc(), rc()};
        bif.B = {rc(), rc()};
        bif.w = {rc(), rc()};
    endtask

    always @(posedge Clk)
        if (Rst_n) begin
            n++;
            hist[n] = bfly(bif.A, bif.B, bif.w);
        end

    // Output for inputs sampled at edge k is visible after edge k+2
    always @(negedge Clk) begin
        logic [63:0] e;
        e = (!Rst_n || n < valid_from + 2) ? 64'h0 : hist[n - 2];
        chk("pipe", {bif.Y, bif.Z}, e);
    end

    logic [95:0] vec [0:3];
    logic [63:0] lit [0:3];
    logic [63:0] r;

    initial begin
        vec[0] = {32'hEF9A0F99, 32'h08001000, 32'hFC000400};
        vec[1] = {32'h04000800, 32'h0C00FC00, 32'h04000000};
        vec[2] = {32'h00000000, 32'h00010000, 32'hFFFF0000};
        vec[3] = {32'h7FFF0000, 32'h7FFF0000, 32'h04000000};
        lit[0] = {32'hD79A0799, 32'h079A1799};
        lit[1] = {32'h10000400, 32'hF8000C00};
        lit[2] = {32'hFFFF0000, 32'h00010000};
`ifdef SATURATE_EN
        lit[3] = {32'h7FFF0000, 32'h00000000};
`else
        lit[3] = {32'hFFFE0000, 32'h00000000};
`endif
        for (int i = 0; i < 4; i++) begin
            r = bfly(vec[i][95:64], vec[i][63:32], vec[i][31:0]);
            chk("model_lit", r, lit[i]);
        end
        bif.A = '0;
        bif.B = '0;
        bif.w = '0;
        #1 Rst_n = 0;
        #1 chk("reset_state", {bif.Y, bif.Z}, 64'h0);
        repeat (2) @(negedge Clk);
        #1 valid_from = n + 1;
        Rst_n = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
            #1;
            if (i >= 3) chk("directed", {bif.Y, bif.Z}, lit[i - 3]);
            if (i < 4) {bif.A, bif.B, bif.w} = vec[i];
            else drive_rand();
        end
        repeat (200) begin
            @(negedge Clk);
            #1 drive_rand();
        end
        // Reset mid-stream with a full pipeline: outputs clear without an edge
        @(negedge Clk);
        #1 drive_rand();
        #2 Rst_n = 0;
        #1 chk("async_reset", {bif.Y, bif.Z}, 64'h0);
        repeat (2) begin
            @(negedge Clk);
            #1 drive_rand();
        end
        @(negedge Clk);
        #1 valid_from = n + 1;
        Rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            #1;
            if (i == 1) chk("post_reset_zero", {bif.Y, bif.Z}, 64'h0);
            if (i == 3) chk("post_reset_first", {bif.Y, bif.Z}, lit[0]);
            if (i == 0) {bif.A, bif.B, bif.w} = vec[0];
            else drive_rand();
        end
        repeat (200) begin
            @(negedge Clk);
            #1 drive_rand();
        end
        @(negedge Clk);
        #1 $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
